instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction-fetch front end that generates the opcodes and instruction words consumed by the control decoder.
- Sequences the PC, issues instruction-memory reads over a valid/ready request channel, and buffers returned words in a small FIFO.
- Presents {opCode, instr, pc} to the decode stage with a valid/ready handshake.
- Handles branch redirects from execute: flushes the buffer and discards stale in-flight responses.

Parameters:
- ADDR_W, 32, PC / instruction-memory byte-address width
- DEPTH, 2, instruction buffer entries (power of 2, >=2)
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  word-aligned fetch address
- imem_resp_valid  in  1  response data valid (always accepted)
- imem_resp_data  in  32  instruction word
- dec_valid  out  1  instruction available to decode
- dec_ready  in  1  decode consumes instruction
- dec_instr  out  32  instruction word
- dec_opCode  out  8  {2'b00, instr[31:26]} fed to decoder opCode input
- dec_pc  out  ADDR_W  PC of presented instruction
- redirect_valid  in  1  branch taken, restart fetch
- redirect_pc  in  ADDR_W  target address (bits [1:0] ignored, forced 0)

Behaviour:
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_opCode=0, dec_pc=0. FIFO empty, state IDLE, epoch=0.
- At most one request outstanding. FSM states:
  - IDLE: if FIFO free slots (DEPTH - count) > 0, go to REQ.
  - REQ: imem_req_valid=1, addr=fetch_pc. On req_valid & req_ready, latch req_epoch=epoch and req_pc=fetch_pc, set fetch_pc += 4, go to WAIT.
  - WAIT: on imem_resp_valid, if req_epoch==epoch push {data, req_pc}, else drop; go to IDLE.
- Slot check counts the in-flight entry, so the FIFO never overflows. Push with a full FIFO is impossible by construction; assert it in simulation.
- Once asserted, imem_req_valid holds until accepted. Address is stable while valid, except on redirect.
- Decode output is the FIFO head, registered; dec_valid = !empty. Pop on dec_valid & dec_ready.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Redirect has priority over every other event in its cycle:
  - FIFO cleared; a same-cycle pop or push is discarded.
  - fetch_pc <= redirect_pc & ~3; epoch toggles.
  - REQ: the pending request is withdrawn and re-issued next cycle with the new address; a same-cycle handshake is ignored.
  - WAIT: remain in WAIT; the stale response is dropped by epoch mismatch.
  - dec_valid = 0 in the following cycle.
- Redirect during reset is ignored. Reset mid-WAIT: any late response arriving after reset is dropped, because reset leaves epoch=0 and also clears a wait_valid flag.
- Throughput: one instruction per 3 cycles with 1-cycle memory latency (single-outstanding design).
- PC arithmetic wraps at 2^ADDR_W.

Optional Feature:
- FETCH_STATS_EN defined: adds outputs stat_fetched (32b, responses pushed) and stat_dropped (32b, stale responses dropped plus FIFO entries flushed by redirect). Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg: opcode constants OP_RTYPE=6'b000000, OP_LW=6'b000100, OP_SW=6'b000101, OP_ADDI=6'b000111, OP_BEQ=6'b000110, OP_ORI=6'b000001; OPCODE_LSB=26; fetch_state_t enum {IDLE, REQ, WAIT}.
- One sub-module: ifu_fifo (DEPTH entries of {instr, pc}, with push/pop/flush, count, empty/full).

Test Plan:
- Straight-line fetch: memory returns 0x1000_0000 + addr with 1-cycle latency, dec_ready=1 -> dec_pc sequence 0,4,8,12; dec_opCode=8'h04 for 0x1000_0000 (opcode 000100).
- Back-pressure: dec_ready=0 for 20 cycles -> exactly DEPTH=2 entries buffered, imem_req_valid stays 0, no lost or duplicated PC once released.
- Redirect in WAIT: redirect_pc=0x40 while response for PC 8 is pending -> PC 8 data dropped, next dec_pc=0x40, dec_valid low one cycle.
- Redirect in REQ with imem_req_ready=1 same cycle -> handshake ignored, next request addr=0x40.
- Redirect coincident with pop and push -> FIFO empty next cycle, no instruction from old path ever presented.
- Reset asserted mid-WAIT, response arrives 2 cycles later -> response dropped, first fetch at RESET_PC; with FETCH_STATS_EN, stat_dropped counts 1 stale response.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: decoder opcode constants, fetch FSM state type
// and the opcode-extraction helper used by the fetch front end.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b000111;
  localparam logic [5:0] OP_BEQ   = 6'b000110;
  localparam logic [5:0] OP_ORI   = 6'b000001;

  localparam int unsigned OPCODE_LSB = 26;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  // Decoder opCode input is the 6-bit major opcode zero-extended to 8 bits.
  function automatic logic [7:0] opcode_of(input logic [31:0] instr);
    return {2'b00, instr[OPCODE_LSB +: 6]};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Instruction buffer for the fetch unit: DEPTH entries of {instr, pc}.
// Flush has priority over push/pop; pointers wrap modulo DEPTH.
module ifu_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [31:0]             push_instr_i,
  input  logic [ADDR_W-1:0]       push_pc_i,
  output logic [31:0]             head_instr_o,
  output logic [ADDR_W-1:0]       head_pc_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]       instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  assign head_instr_o = instr_q[rd_ptr_q];
  assign head_pc_o    = pc_q[rd_ptr_q];
  assign count_o      = count_q;

  // Storage, pointer and occupancy update; flush empties without clearing storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        instr_q[wr_ptr_q] <= push_instr_i;
        pc_q[wr_ptr_q]    <= push_pc_i;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The fetch FSM reserves a slot before requesting, so a push never meets a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full && !flush_i));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: PC sequencing, single-outstanding imem
// request channel, instruction buffer and decode handshake with branch
// redirect/flush. Optional statistics counters: define FETCH_STATS_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_instr,
  output logic [7:0]        dec_opCode,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_dropped
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t      state_q;
  logic              req_valid_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              epoch_q;
  logic              req_epoch_q;
  logic              wait_valid_q;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [31:0]       head_instr;
  logic [ADDR_W-1:0] head_pc;

  logic              req_hs;
  logic              resp_ok;
  logic              push;
  logic              pop;
  logic              resp_drop;

  assign req_hs  = (state_q == REQ) & req_valid_q & imem_req_ready;
  assign resp_ok = imem_resp_valid & (state_q == WAIT) & wait_valid_q &
                   (req_epoch_q == epoch_q);
  assign push      = resp_ok & ~redirect_valid;
  assign resp_drop = imem_resp_valid & ~push;
  assign pop       = ~fifo_empty & dec_ready;

  ifu_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .pop_i        (pop),
    .push_instr_i (imem_resp_data),
    .push_pc_i    (req_pc_q),
    .head_instr_o (head_instr),
    .head_pc_o    (head_pc),
    .count_o      (fifo_count),
    .empty_o      (fifo_empty)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign dec_valid      = ~fifo_empty;
  assign dec_instr      = head_instr;
  assign dec_opCode     = opcode_of(head_instr);
  assign dec_pc         = head_pc;

  // Fetch FSM: reserve a buffer slot, issue one request, await its response.
  // A redirect retargets fetch_pc and bumps the epoch; a request in flight stays
  // in WAIT and its response is discarded by the epoch mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      epoch_q      <= 1'b0;
      req_epoch_q  <= 1'b0;
      wait_valid_q <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc & ~ADDR_W'(3);
        epoch_q    <= ~epoch_q;
      end
      case (state_q)
        IDLE: begin
          // After a redirect the buffer is flushed, so a slot is always free.
          if (redirect_valid || (fifo_count < DEPTH_C)) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
          end
        end
        REQ: begin
          if (req_hs && !redirect_valid) begin
            req_epoch_q  <= epoch_q;
            req_pc_q     <= fetch_pc_q;
            fetch_pc_q   <= fetch_pc_q + ADDR_W'(4);
            wait_valid_q <= 1'b1;
            req_valid_q  <= 1'b0;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            wait_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          req_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q;
  logic [31:0] dropped_q;
  logic [32:0] drop_sum;

  assign drop_sum = {1'b0, dropped_q} + 33'(resp_drop) +
                    (redirect_valid ? 33'(fifo_count) : 33'd0);

  // Saturating counters of pushed responses and discarded work.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      if (push && (fetched_q != '1)) begin
        fetched_q <= fetched_q + 32'd1;
      end
      dropped_q <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [7:0]  dec_opCode;
  logic [31:0] dec_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_dropped;
`endif

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_opCode      (dec_opCode),
    .dec_pc          (dec_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched    (stat_fetched),
    .stat_dropped    (stat_dropped)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors    = 0;
  int miscompares = 0;

  // Memory model state: one response lat cycles after each accepted request.
  int          lat   = 1;
  int          pend_t = 0;
  logic [31:0] pend_a = '0;
  bit          hashed = 0;

  // Reference model: the decode stream is program order from the last restart point.
  logic [31:0] exp_pc = RESET_PC;
  int          consumed = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (hashed) return a * 32'h9E37_79B1 + 32'h1000_0000;
    return 32'h1000_0000 + a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout waiting for DUT event", nm);
  endtask

  // One clock: model consumption before the edge, memory response after it.
  task automatic step();
    logic        hs;
    logic [31:0] a;
    logic [31:0] w;
    bit          redir_now;
    if (!rst && dec_valid && dec_ready && !redirect_valid) begin
      w = mem_word(exp_pc);
      chk("dec_pc", dec_pc, exp_pc);
      chk("dec_instr", dec_instr, w);
      chk("dec_opCode", {24'b0, dec_opCode}, {26'b0, w[31:26]});
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    hs = imem_req_valid & imem_req_ready;
    a = imem_req_addr;
    redir_now = redirect_valid & !rst;
    if (rst) exp_pc = RESET_PC;
    else if (redir_now) exp_pc = redirect_pc & ~32'h3;
    @(posedge clk);
    #1;
    if (hs === 1'b1) begin
      pend_t = lat;
      pend_a = a;
    end
    if (pend_t > 0) begin
      pend_t--;
      imem_resp_valid = (pend_t == 0);
      imem_resp_data = mem_word(pend_a);
    end else begin
      imem_resp_valid = 1'b0;
    end
    if (redir_now) chk("dec_valid_after_redirect", {31'b0, dec_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        drdy;
    logic        ex_rv;
    logic [31:0] ex_addr;
    logic        ex_dv;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] ad,
                              input logic dv, input logic [31:0] pc, input logic [31:0] ins);
    vec_t v;
    v.rst = r; v.rdy = 1'b1; v.drdy = 1'b1;
    v.ex_rv = rv; v.ex_addr = ad; v.ex_dv = dv; v.ex_pc = pc; v.ex_instr = ins;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    int n;
    int c0;
    logic [31:0] w;

    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // Straight-line fetch, 1-cycle memory, decode always ready: 3-cycle cadence.
    tbl[0]  = mk(1'b1, 1'b0, 32'd0,  1'b0, 32'd0,  32'h0000_0000);
    tbl[1]  = mk(1'b0, 1'b1, 32'd0,  1'b0, 32'd0,  32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 32'd4,  1'b0, 32'd0,  32'h0);
    tbl[3]  = mk(1'b0, 1'b0, 32'd4,  1'b1, 32'd0,  32'h1000_0000);
    tbl[4]  = mk(1'b0, 1'b1, 32'd4,  1'b0, 32'd0,  32'h0);
    tbl[5]  = mk(1'b0, 1'b0, 32'd8,  1'b0, 32'd0,  32'h0);
    tbl[6]  = mk(1'b0, 1'b0, 32'd8,  1'b1, 32'd4,  32'h1000_0004);
    tbl[7]  = mk(1'b0, 1'b1, 32'd8,  1'b0, 32'd0,  32'h0);
    tbl[8]  = mk(1'b0, 1'b0, 32'd12, 1'b0, 32'd0,  32'h0);
    tbl[9]  = mk(1'b0, 1'b0, 32'd12, 1'b1, 32'd8,  32'h1000_0008);
    tbl[10] = mk(1'b0, 1'b1, 32'd12, 1'b0, 32'd0,  32'h0);
    tbl[11] = mk(1'b0, 1'b0, 32'd16, 1'b0, 32'd0,  32'h0);
    tbl[12] = mk(1'b0, 1'b0, 32'd16, 1'b1, 32'd12, 32'h1000_000C);

    lat = 1;
    hashed = 0;
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst;
      imem_req_ready = tbl[i].rdy;
      dec_ready = tbl[i].drdy;
      step();
      chk("tbl_req_valid", {31'b0, imem_req_valid}, {31'b0, tbl[i].ex_rv});
      chk("tbl_req_addr", imem_req_addr, tbl[i].ex_addr);
      chk("tbl_dec_valid", {31'b0, dec_valid}, {31'b0, tbl[i].ex_dv});
      if (tbl[i].ex_dv || tbl[i].rst) begin
        w = tbl[i].ex_instr;
        chk("tbl_dec_pc", dec_pc, tbl[i].ex_pc);
        chk("tbl_dec_instr", dec_instr, w);
        chk("tbl_dec_opCode", {24'b0, dec_opCode}, {26'b0, w[31:26]});
      end
    end
    rst = 1'b0;

    // Back-pressure: buffer fills to DEPTH, fetch stalls, then drains in order.
    dec_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 10) chk("bp_req_valid_idle", {31'b0, imem_req_valid}, 32'd0);
    end
    chk("bp_dec_valid", {31'b0, dec_valid}, 32'd1);
    c0 = consumed;
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("bp_buffered_count", consumed - c0, DEPTH);
    for (int i = 0; i < 12; i++) step();

    // Redirect while the response for PC 8 is outstanding (2-cycle memory).
    imem_req_ready = 1'b1;
    do_reset();
    lat = 2;
    n = 0;
    while (!(imem_req_valid && imem_req_ready && imem_req_addr == 32'd8) && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) timeout("wait_req_pc8");
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    step();
    redirect_valid = 1'b0;
    n = 0;
    while (!dec_valid && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) timeout("wait_after_redirect_wait");
    chk("redir_wait_dec_pc", dec_pc, 32'h40);
    for (int i = 0; i < 12; i++) step();

    // Redirect in REQ with a coincident handshake: request re-issued at target.
    lat = 1;
    imem_req_ready = 1'b0;
    do_reset();
    n = 0;
    while (!imem_req_valid && n < 10) begin
      step();
      n++;
    end
    if (n >= 10) timeout("wait_req_valid");
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("redir_req_addr", imem_req_addr, 32'h40);
    for (int i = 0; i < 15; i++) step();

    // Redirect coincident with a pop and a push.
    dec_ready = 1'b0;
    do_reset();
    n = 0;
    while (!(dec_valid && imem_resp_valid) && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) timeout("wait_push_pop");
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_STATS_EN
    chk("stat_dropped_flush", stat_dropped, 32'd2);
`endif
    for (int i = 0; i < 15; i++) step();

    // Reset while waiting; the late response must not be presented.
    lat = 2;
    n = 0;
    while (!(imem_req_valid && imem_req_ready) && n < 10) begin
      step();
      n++;
    end
    if (n >= 10) timeout("wait_hs_before_reset");
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_stale_resp_arrives", {31'b0, imem_resp_valid}, 32'd1);
    step();
    chk("rst_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rst_first_req_addr", imem_req_addr, RESET_PC);
`ifdef FETCH_STATS_EN
    chk("stat_dropped_stale", stat_dropped, 32'd1);
    chk("stat_fetched_zero", stat_fetched, 32'd0);
`endif
    imem_req_ready = 1'b1;
    n = 0;
    while (!dec_valid && n < 10) begin
      step();
      n++;
    end
    if (n >= 10) timeout("wait_after_reset");
    chk("rst_first_dec_pc", dec_pc, RESET_PC);
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic against the program-order model.
    hashed = 1;
    do_reset();
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      lat = int'($urandom_range(1, 2));
      imem_req_ready = ($urandom_range(0, 3) != 0);
      dec_ready = $urandom_range(0, 1) != 0;
      redirect_valid = ($urandom_range(0, 49) == 0);
      redirect_pc = $urandom & 32'h0000_FFFF;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    vectors++;
    if (consumed - c0 < 50) begin
      miscompares++;
      $display("FAIL random_progress: got %0d consumed expected at least 50", consumed - c0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
